// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the mem stage. Accepts one load/store
//            at a time over a valid/ready request channel, waits a fixed
//            access latency, then presents the result on a valid/ready
//            response channel. Misaligned or out-of-range accesses are
//            flagged on rsp_err and never touch the storage array.
// Ports    : clk                 rising-edge clock
//            rst                 asynchronous reset, active low
//            req_valid/req_ready request handshake
//            req_addr            byte address (bit 0 must be 0)
//            req_wr/req_wdata    1 = store, store data
//            rsp_valid/rsp_ready response handshake
//            rsp_rdata           load data (0 for stores and errors)
//            rsp_err             misaligned or out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_wr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS < 1 || DEPTH_WORDS > 32768) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be in 1..32768");
    end
  endgenerate

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [15:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [15:0]   acc_addr;
  logic          acc_wr;
  logic [15:0]   acc_wdata;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [15:0]   mem_rd;
  logic          mem_we;

  // Outputs come straight from flops; ready/valid are precomputed from the
  // next state so they track the FSM with no combinational path from inputs.
  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept = req_valid && ready_q && (state_q == S_IDLE);

  // The storage access happens on the edge that enters RESP. With a
  // one-cycle latency that is the acceptance edge itself, so the live
  // request inputs must be used instead of the latched copy.
  assign enter_resp = ((state_q == S_IDLE) && accept && (LATENCY == 1)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd1));

  assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign acc_wr    = (state_q == S_IDLE) ? req_wr    : wr_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  assign acc_err = acc_addr[0] || (32'(acc_addr[15:1]) >= DEPTH_WORDS);
  assign acc_idx = acc_addr[AW:1];
  assign mem_rd  = mem[acc_idx];
  assign mem_we  = enter_resp && acc_wr && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wr_d    = req_wr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= guards against a stuck zero count; normal entry is never 0.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_wr) ? 16'd0 : mem_rd;
    end else if ((state_q == S_RESP) && rsp_ready) begin
      err_d   = 1'b0;
      rdata_d = 16'd0;
    end

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wr_q    <= 1'b0;
      wdata_q <= 16'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset. A store aborted by reset while in
  // WAIT never reaches enter_resp, so it leaves the array untouched.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

`ifndef SYNTHESIS
  a_no_overlap : assert property (@(posedge clk) disable iff (!rst)
    !(rsp_valid && req_ready));
  a_valid_in_resp : assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> (state_q == S_RESP));
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Two instances are used:
//            one with LATENCY=2 (directed + randomized traffic, backpressure,
//            reset mid-WAIT) and one with LATENCY=1 (back-to-back throughput).
//            Expected responses come from a word-array model of the storage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // LATENCY = 2 instance
  logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  // LATENCY = 1 instance
  logic        req_valid1, req_ready1, req_wr1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [15:0] req_addr1, req_wdata1, rsp_rdata1;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .req_wr(req_wr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference storage, one per instance, plus "has been written" flags.
  logic [15:0] m0 [256];
  bit          k0 [256];
  logic [15:0] m1 [256];
  bit          k1 [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_err(input logic [15:0] a);
    return a[0] || (a[15:1] >= 15'd256);
  endfunction

  // Model of one access on a storage array: returns expected rdata/err.
  task automatic model(input bit which, input logic [15:0] a, input logic wr,
                       input logic [15:0] wd, output logic [15:0] er, output logic ee);
    ee = exp_err(a);
    er = 16'd0;
    if (!ee) begin
      if (wr) begin
        if (which) begin m1[a[8:1]] = wd; k1[a[8:1]] = 1'b1; end
        else       begin m0[a[8:1]] = wd; k0[a[8:1]] = 1'b1; end
      end else begin
        er = which ? m1[a[8:1]] : m0[a[8:1]];
      end
    end
  endtask

  // One transaction on the LATENCY=2 instance. Starts and ends at a negedge.
  // stall > 0 holds rsp_ready low for that many response cycles while a
  // competing request is offered.
  task automatic txn(input logic [15:0] a, input logic wr, input logic [15:0] wd, input int stall);
    logic [15:0] er;
    logic        ee;
    int          n;
    model(1'b0, a, wr, wd, er, ee);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_wr = wr; req_wdata = wd;
    rsp_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("latency", n, 2);
    check("rsp_rdata", rsp_rdata, er);
    check("rsp_err", rsp_err, ee);
    check("ready_in_resp", req_ready, 0);
    if (stall > 0) begin
      req_valid = 1'b1; req_addr = 16'h0000; req_wr = 1'b1; req_wdata = 16'hDEAD;
      for (int s = 0; s < stall; s++) begin
        check("stall_valid", rsp_valid, 1);
        check("stall_rdata", rsp_rdata, er);
        check("stall_err", rsp_err, ee);
        check("stall_ready", req_ready, 0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
    end
    @(negedge clk);
    check("post_valid", rsp_valid, 0);
    check("post_ready", req_ready, 1);
    check("post_rdata", rsp_rdata, 0);
    check("post_err", rsp_err, 0);
  endtask

  logic [15:0] ra, rwd;
  logic        rwr;
  int unsigned kind, w;
  logic [15:0] op_a  [16];
  logic        op_wr [16];
  logic [15:0] op_wd [16];

  initial begin
    rst = 1'b0;
    req_valid = 0; req_addr = 0; req_wr = 0; req_wdata = 0; rsp_ready = 1;
    req_valid1 = 0; req_addr1 = 0; req_wr1 = 0; req_wdata1 = 0; rsp_ready1 = 1;
    for (int i = 0; i < 256; i++) begin k0[i] = 0; k1[i] = 0; m0[i] = 0; m1[i] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_ready1", req_ready1, 0);
    rst = 1'b1;
    #1 check("ready_at_release", req_ready, 0);
    @(negedge clk);
    check("ready_after_release", req_ready, 1);

    // Directed traffic
    txn(16'h0010, 1'b1, 16'hBEEF, 0);
    txn(16'h0010, 1'b0, 16'h0000, 0);
    txn(16'h0011, 1'b1, 16'h1234, 0);
    txn(16'h0010, 1'b0, 16'h0000, 0);
    txn(16'h01FE, 1'b1, 16'h7777, 0);
    txn(16'h0200, 1'b0, 16'h0000, 0);
    txn(16'h01FE, 1'b0, 16'h0000, 0);
    txn(16'h0010, 1'b0, 16'h0000, 5);
    txn(16'h0000, 1'b1, 16'h0F0F, 0);
    txn(16'h0000, 1'b0, 16'h0000, 0);

    // Reset while a store is in WAIT
    txn(16'h0020, 1'b1, 16'h5555, 0);
    req_valid = 1'b1; req_addr = 16'h0020; req_wr = 1'b1; req_wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("wait_valid", rsp_valid, 0);
    rst = 1'b0;
    #1;
    check("midrst_ready", req_ready, 0);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_rdata", rsp_rdata, 0);
    check("midrst_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_at_release2", req_ready, 0);
    @(negedge clk);
    check("ready_after_release2", req_ready, 1);
    txn(16'h0020, 1'b0, 16'h0000, 0);

    // Randomized traffic on the LATENCY=2 instance
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 31);
      rwr  = 1'($urandom_range(0, 1));
      rwd  = 16'($urandom);
      if (kind <= 5)      ra = 16'(w * 2);
      else if (kind <= 7) ra = 16'(w * 2 + 1);
      else                ra = 16'($urandom_range(256, 32767) * 2 + $urandom_range(0, 1));
      if (kind <= 5 && !rwr && !k0[w]) rwr = 1'b1;
      txn(ra, rwr, rwd, int'($urandom_range(0, 3)));
    end

    // LATENCY=1 instance: back-to-back with req_valid held high
    op_a[0] = 16'h0000; op_wr[0] = 1; op_wd[0] = 16'h0001;
    op_a[1] = 16'h0002; op_wr[1] = 1; op_wd[1] = 16'h0002;
    op_a[2] = 16'h0004; op_wr[2] = 1; op_wd[2] = 16'h0003;
    op_a[3] = 16'h0000; op_wr[3] = 0; op_wd[3] = 16'h0000;
    op_a[4] = 16'h0002; op_wr[4] = 0; op_wd[4] = 16'h0000;
    op_a[5] = 16'h0004; op_wr[5] = 0; op_wd[5] = 16'h0000;
    for (int i = 6; i < 16; i++) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 7);
      op_wd[i] = 16'($urandom);
      op_wr[i] = 1'($urandom_range(0, 1));
      if (kind <= 6)      op_a[i] = 16'(w * 2);
      else if (kind == 7) op_a[i] = 16'(w * 2 + 1);
      else                op_a[i] = 16'($urandom_range(256, 32767) * 2);
    end
    check("l1_ready_start", req_ready1, 1);
    req_valid1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] er;
      logic        ee;
      if (!op_wr[i] && !exp_err(op_a[i]) && !k1[op_a[i][8:1]]) op_wr[i] = 1'b1;
      req_addr1 = op_a[i]; req_wr1 = op_wr[i]; req_wdata1 = op_wd[i];
      model(1'b1, op_a[i], op_wr[i], op_wd[i], er, ee);
      check("l1_ready_idle", req_ready1, 1);
      check("l1_valid_idle", rsp_valid1, 0);
      @(negedge clk);
      check("l1_valid_resp", rsp_valid1, 1);
      check("l1_ready_resp", req_ready1, 0);
      check("l1_rdata", rsp_rdata1, er);
      check("l1_err", rsp_err1, ee);
      if (i == 15) req_valid1 = 1'b0;
      @(negedge clk);
    end
    check("l1_ready_end", req_ready1, 1);
    check("l1_valid_end", rsp_valid1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that services the mem stage's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Holds one outstanding transaction at a time.
- Models configurable access latency, applies backpressure, and flags misaligned or out-of-range accesses; the flag feeds the pipeline error output.
- Sits between the mem stage (initiator) and the word-organised data storage.

Parameters:
- DEPTH_WORDS, 256: number of 16-bit words in the storage array.
- LATENCY, 2: cycles from request acceptance to first rsp_valid cycle. Legal range is 1..15; other values are illegal (elaboration-time assertion).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  16  byte address; bit 0 must be 0; word index is req_addr[15:1].
- req_wr  input  1  1 = store, 0 = load.
- req_wdata  input  16  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response this cycle.
- rsp_rdata  output  16  load data; 0 for stores and errored accesses.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- **States:** IDLE, WAIT, RESP.
- **Reset (rst low, asynchronous):**
  - state goes to IDLE; latency counter = 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage array is not reset.
  - req_ready rises in the first cycle after rst deasserts.
- **IDLE:**
  - req_ready=1.
  - Acceptance occurs when req_valid and req_ready are both high at a rising edge. On acceptance, latch addr, wr and wdata.
  - If LATENCY=1, go to RESP.
  - Otherwise go to WAIT, with counter loaded to LATENCY-1.
- **WAIT:**
  - req_ready=0; req_valid is ignored.
  - Counter decrements each cycle; go to RESP on the edge where counter==1.
- **Timing:** for a request accepted in cycle t, rsp_valid is high from cycle t+LATENCY.
- **Storage access:** performed on the edge that enters RESP, using the latched request. For LATENCY=1 this is the acceptance edge, so the live request inputs are used.
- **Error check:** err = req_addr[0] | (req_addr[15:1] >= DEPTH_WORDS).
- **Errored access:** no storage write, rsp_rdata=0, rsp_err=1.
- **Valid store:** writes wdata to the array; rsp_rdata=0, rsp_err=0.
- **Valid load:** rsp_rdata=array[word index], rsp_err=0.
- **RESP:**
  - rsp_valid=1; rsp_rdata and rsp_err are registered and held stable until handshake.
  - req_ready=0.
  - On rsp_valid & rsp_ready: go to IDLE, and rsp_valid/rsp_rdata/rsp_err clear to 0 at that edge.
  - There is no same-cycle re-acceptance, so maximum throughput is one transaction per LATENCY+1 cycles.
- **Reset mid-operation:**
  - A store still in WAIT is discarded; the array is unchanged.
  - A store already in RESP has committed.
- **Protocol assertions:**
  - rsp_valid and req_ready are never high together.
  - rsp_valid is never high outside RESP.
  - rsp_rdata and rsp_err are stable while rsp_valid & !rsp_ready.

Test Plan:
- **LATENCY=2, rsp_ready=1.**
  - Store 0x0010 ← 0xBEEF, accepted in cycle 0: rsp_valid in cycle 2, err=0, rdata=0, req_ready high again in cycle 3.
  - Then load 0x0010: rdata=0xBEEF, err=0.
- **Misaligned store 0x0011 ← 0x1234:** rsp_err=1, rdata=0. A following load of 0x0010 still returns 0xBEEF.
- **Out of range (DEPTH_WORDS=256):**
  - Load 0x0200 (word 256): err=1, rdata=0.
  - Load 0x01FE (word 255), previously stored 0x7777: err=0, rdata=0x7777.
- **Backpressure:**
  - Load completes with rsp_ready held low for 5 cycles: rsp_valid, rdata and err are constant for all 5 cycles, and req_ready=0.
  - A concurrent req_valid is not accepted.
  - After rsp_ready rises, IDLE is reached the next cycle.
- **Reset mid-WAIT:**
  - Store 0x0020 ← 0x5555 and complete it.
  - Accept store 0x0020 ← 0xAAAA, then pull rst low in the WAIT cycle: all outputs go 0 immediately.
  - After release, a load of 0x0020 returns 0x5555.
- **LATENCY=1, rsp_ready tied high:**
  - Stores 0x0000←0x0001, 0x0002←0x0002, 0x0004←0x0003 with req_valid held high: acceptances in cycles 0, 2, 4 and responses in cycles 1, 3, 5.
  - Subsequent loads return 0x0001, 0x0002, 0x0003.
